simd_inst_issue: RTL and testbench

- Downstream neighbour of the SIMD driver. Accepts the `(pc, warpid, bofs, aofs)` stream on the `inst` rdy/ack channel.
- Decodes `pc` against the per-tile instruction config registers and issues decoded ops to the ALU pipeline through a 2-stage rdy/ack pipeline.
- Tracks issued-but-uncompleted ops in an in-order pending queue, and returns `inst_commit` dval pulses that close the driver's pending-instruction semaphore.

---
 rtl/simd_inst_issue_pkg.sv | 30 +++
 rtl/simd_inst_issue_if.sv | 48 ++++
 rtl/simd_pending_fifo.sv | 66 ++++++
 rtl/simd_inst_issue.sv | 174 +++++++++++++++++
 tb/tb_simd_inst_issue.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simd_inst_issue_pkg.sv
// ============================================================================
// simd_inst_issue_pkg : shared configuration for the SIMD instruction issue path
// Rev 1.0
// ============================================================================
`default_nettype none

package simd_inst_issue_pkg;

  localparam int CFG_N_INST           = 4;
  localparam int CFG_VDIM             = 2;
  localparam int CFG_WORK_BW          = 8;
  localparam int CFG_MAX_WARP         = 4;
  localparam int CFG_MAX_PENDING_INST = 4;
  localparam int CFG_OP_BW            = 8;

  localparam int CFG_INST_BW = $clog2(CFG_N_INST + 1);
  localparam int CFG_WID_BW  = $clog2(CFG_MAX_WARP);

  localparam logic [CFG_OP_BW-1:0] OP_NOP = '0;

  typedef enum logic [1:0] {
    SRC_BOFS = 2'd0,
    SRC_AOFS = 2'd1,
    SRC_IMM  = 2'd2,
    SRC_REG  = 2'd3
  } src_sel_e;

endpackage

`default_nettype wire

// File: rtl/simd_inst_issue_if.sv
// ============================================================================
// simd_inst_if / simd_alu_if : rdy/ack channels into and out of the issue stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface simd_inst_if
  import simd_inst_issue_pkg::*;
#(
  parameter int INST_BW = CFG_INST_BW,
  parameter int WID_BW  = CFG_WID_BW,
  parameter int WBW     = CFG_WORK_BW,
  parameter int VDIM    = CFG_VDIM
);
  logic                          rdy;
  logic                          ack;
  logic [INST_BW-1:0]            pc;
  logic [WID_BW-1:0]             warpid;
  logic [VDIM-1:0][WBW-1:0]      bofs;
  logic [VDIM-1:0][WBW-1:0]      aofs;

  modport master (output rdy, pc, warpid, bofs, aofs, input ack);
  modport slave  (input rdy, pc, warpid, bofs, aofs, output ack);
endinterface

interface simd_alu_if
  import simd_inst_issue_pkg::*;
#(
  parameter int INST_BW = CFG_INST_BW,
  parameter int WID_BW  = CFG_WID_BW,
  parameter int WBW     = CFG_WORK_BW,
  parameter int VDIM    = CFG_VDIM,
  parameter int OP_BW   = CFG_OP_BW
);
  logic                          rdy;
  logic                          ack;
  logic [OP_BW-1:0]              opcode;
  logic [1:0]                    src_sel;
  logic [INST_BW-1:0]            pc;
  logic [WID_BW-1:0]             warpid;
  logic [VDIM-1:0][WBW-1:0]      bofs;
  logic [VDIM-1:0][WBW-1:0]      aofs;

  modport master (output rdy, opcode, src_sel, pc, warpid, bofs, aofs, input ack);
  modport slave  (input rdy, opcode, src_sel, pc, warpid, bofs, aofs, output ack);
endinterface

`default_nettype wire

// File: rtl/simd_pending_fifo.sv
// ============================================================================
// simd_pending_fifo : circular FIFO of issued-but-uncompleted warp ids
// Rev 1.0
// ============================================================================
`default_nettype none

module simd_pending_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_BW-1:0] r_wr_ptr;
  logic [PTR_BW-1:0] r_rd_ptr;
  logic [CNT_BW-1:0] r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  function automatic logic [PTR_BW-1:0] ptr_inc(input logic [PTR_BW-1:0] p);
    return (p == PTR_BW'(DEPTH - 1)) ? '0 : p + PTR_BW'(1);
  endfunction

  assign full      = (r_count == CNT_BW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_ok) r_rd_ptr <= ptr_inc(r_rd_ptr);
      // Simultaneous push and pop leave the occupancy unchanged
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_BW'(1);
        2'b01:   r_count <= r_count - CNT_BW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/simd_inst_issue.sv
// ============================================================================
// simd_inst_issue : decode + issue pipeline with in-order commit tracking
// Rev 1.0
// ============================================================================
`default_nettype none

module simd_inst_issue
  import simd_inst_issue_pkg::*;
#(
  parameter int N_INST    = CFG_N_INST,
  parameter int VDIM      = CFG_VDIM,
  parameter int WBW       = CFG_WORK_BW,
  parameter int MAX_WARP  = CFG_MAX_WARP,
  parameter int N_PENDING = CFG_MAX_PENDING_INST,
  parameter int OP_BW     = CFG_OP_BW
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  simd_inst_if.slave                    inst,
  input  logic [N_INST-1:0][OP_BW-1:0]  i_opcodes,
  input  logic [N_INST-1:0][1:0]        i_src_sel,
  simd_alu_if.master                    alu,
  input  logic                          alu_done_dval,
  output logic                          inst_commit_dval,
  output logic [$clog2(MAX_WARP)-1:0]   o_commit_warpid,
  output logic                          o_err_underflow
);

  localparam int INST_BW = $clog2(N_INST + 1);
  localparam int WID_BW  = $clog2(MAX_WARP);
  localparam int CNT_BW  = $clog2(N_PENDING + 1);

  // Stage D (decode)
  logic                     r_d_valid;
  logic [INST_BW-1:0]       r_d_pc;
  logic [WID_BW-1:0]        r_d_warpid;
  logic [VDIM-1:0][WBW-1:0] r_d_bofs;
  logic [VDIM-1:0][WBW-1:0] r_d_aofs;
  logic [OP_BW-1:0]         r_d_opcode;
  src_sel_e                 r_d_src_sel;

  // Stage I (issue)
  logic                     r_iss_valid;
  logic [INST_BW-1:0]       r_iss_pc;
  logic [WID_BW-1:0]        r_iss_warpid;
  logic [VDIM-1:0][WBW-1:0] r_iss_bofs;
  logic [VDIM-1:0][WBW-1:0] r_iss_aofs;
  logic [OP_BW-1:0]         r_iss_opcode;
  src_sel_e                 r_iss_src_sel;

  logic                     r_commit_dval;
  logic [WID_BW-1:0]        r_commit_warpid;
  logic                     r_err_underflow;

  logic                     w_q_full;
  logic                     w_q_empty;
  logic [CNT_BW-1:0]        w_q_count;
  logic [WID_BW-1:0]        w_q_rdata;
  logic                     w_alu_rdy;
  logic                     w_iss_fire;
  logic                     w_d_moves;
  logic                     w_inst_ack;
  logic                     w_inst_fire;
  logic                     w_pop;
  logic                     w_underflow;
  logic [OP_BW-1:0]         w_dec_opcode;
  src_sel_e                 w_dec_src_sel;

  assign w_alu_rdy   = r_iss_valid && !w_q_full;
  assign w_iss_fire  = w_alu_rdy && alu.ack;
  assign w_d_moves   = r_d_valid && (!r_iss_valid || w_iss_fire);
  assign w_inst_ack  = inst.rdy && (!r_d_valid || w_d_moves);
  assign w_inst_fire = inst.rdy && w_inst_ack;
  assign w_pop       = alu_done_dval && !w_q_empty;
  assign w_underflow = alu_done_dval && (w_q_count == '0);

  // Any pc outside the table (including N_INST) falls through to a NOP
  always_comb begin
    w_dec_opcode  = OP_NOP;
    w_dec_src_sel = SRC_BOFS;
    for (int k = 0; k < N_INST; k++) begin
      if (inst.pc == INST_BW'(k)) begin
        w_dec_opcode  = i_opcodes[k];
        w_dec_src_sel = src_sel_e'(i_src_sel[k]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d_valid   <= 1'b0;
      r_d_pc      <= '0;
      r_d_warpid  <= '0;
      r_d_bofs    <= '0;
      r_d_aofs    <= '0;
      r_d_opcode  <= '0;
      r_d_src_sel <= SRC_BOFS;
    end else if (w_inst_fire) begin
      r_d_valid   <= 1'b1;
      r_d_pc      <= inst.pc;
      r_d_warpid  <= inst.warpid;
      r_d_bofs    <= inst.bofs;
      r_d_aofs    <= inst.aofs;
      r_d_opcode  <= w_dec_opcode;
      r_d_src_sel <= w_dec_src_sel;
    end else if (w_d_moves) begin
      r_d_valid   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_iss_valid   <= 1'b0;
      r_iss_pc      <= '0;
      r_iss_warpid  <= '0;
      r_iss_bofs    <= '0;
      r_iss_aofs    <= '0;
      r_iss_opcode  <= '0;
      r_iss_src_sel <= SRC_BOFS;
    end else if (w_d_moves) begin
      r_iss_valid   <= 1'b1;
      r_iss_pc      <= r_d_pc;
      r_iss_warpid  <= r_d_warpid;
      r_iss_bofs    <= r_d_bofs;
      r_iss_aofs    <= r_d_aofs;
      r_iss_opcode  <= r_d_opcode;
      r_iss_src_sel <= r_d_src_sel;
    end else if (w_iss_fire) begin
      r_iss_valid   <= 1'b0;
    end
  end

  simd_pending_fifo #(
    .DEPTH (N_PENDING),
    .WIDTH (WID_BW)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (w_iss_fire),
    .push_data (r_iss_warpid),
    .pop       (w_pop),
    .pop_data  (w_q_rdata),
    .full      (w_q_full),
    .empty     (w_q_empty),
    .count     (w_q_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_commit_dval   <= 1'b0;
      r_commit_warpid <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_commit_dval <= w_pop;
      if (w_pop)       r_commit_warpid <= w_q_rdata;
      if (w_underflow) r_err_underflow <= 1'b1;
    end
  end

  assign inst.ack         = w_inst_ack;
  assign alu.rdy          = w_alu_rdy;
  assign alu.opcode       = r_iss_opcode;
  assign alu.src_sel      = r_iss_src_sel;
  assign alu.pc           = r_iss_pc;
  assign alu.warpid       = r_iss_warpid;
  assign alu.bofs         = r_iss_bofs;
  assign alu.aofs         = r_iss_aofs;
  assign inst_commit_dval = r_commit_dval;
  assign o_commit_warpid  = r_commit_warpid;
  assign o_err_underflow  = r_err_underflow;

endmodule

`default_nettype wire

// File: tb/tb_simd_inst_issue.sv
// ============================================================================
// tb_simd_inst_issue : directed self-checking bench for simd_inst_issue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_simd_inst_issue;
  import simd_inst_issue_pkg::*;

  localparam int N_INST  = CFG_N_INST;
  localparam int OP_BW   = CFG_OP_BW;
  localparam int INST_BW = CFG_INST_BW;
  localparam int WID_BW  = CFG_WID_BW;

  logic clk = 1'b0;
  logic rst;
  logic done;
  logic commit_dval;
  logic [WID_BW-1:0] commit_wid;
  logic err;
  logic [N_INST-1:0][OP_BW-1:0] opcodes;
  logic [N_INST-1:0][1:0]       src_tab;

  int n_checks = 0;
  int n_errors = 0;
  int s_pc  [32];
  int s_wid [32];
  int n_src;
  int op_idx;

  always #5 clk = ~clk;

  simd_inst_if inst_bus ();
  simd_alu_if  alu_bus ();

  simd_inst_issue dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .inst             (inst_bus),
    .i_opcodes        (opcodes),
    .i_src_sel        (src_tab),
    .alu              (alu_bus),
    .alu_done_dval    (done),
    .inst_commit_dval (commit_dval),
    .o_commit_warpid  (commit_wid),
    .o_err_underflow  (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] tag_bofs(input int t);
    return {8'(t + 16), 8'(t)};
  endfunction

  function automatic logic [15:0] tag_aofs(input int t);
    return {8'(t + 32), 8'(t)};
  endfunction

  // Op number op_idx+1 is used as the data tag of each stream entry
  task automatic load_src();
    if (op_idx < n_src) begin
      inst_bus.rdy    = 1'b1;
      inst_bus.pc     = INST_BW'(s_pc[op_idx]);
      inst_bus.warpid = WID_BW'(s_wid[op_idx]);
      inst_bus.bofs   = tag_bofs(op_idx + 1);
      inst_bus.aofs   = tag_aofs(op_idx + 1);
    end else begin
      inst_bus.rdy    = 1'b0;
    end
  endtask

  task automatic start_stream(input int n);
    op_idx = 0;
    n_src  = n;
    load_src();
    #1;
  endtask

  task automatic tick(input logic d);
    logic fire;
    done = d;
    fire = inst_bus.rdy && inst_bus.ack;
    @(posedge clk);
    #1;
    done = 1'b0;
    if (fire) begin
      op_idx++;
      load_src();
    end
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    done            = 1'b0;
    alu_bus.ack     = 1'b0;
    inst_bus.rdy    = 1'b0;
    inst_bus.pc     = '0;
    inst_bus.warpid = '0;
    inst_bus.bofs   = '0;
    inst_bus.aofs   = '0;
    n_src           = 0;
    op_idx          = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    opcodes = {8'd8, 8'd7, 8'd6, 8'd5};
    src_tab = {2'd3, 2'd2, 2'd1, 2'd0};
    do_reset();

    // Reset state
    check_eq("rst_alu_rdy", 32'(alu_bus.rdy), 32'd0);
    check_eq("rst_inst_ack", 32'(inst_bus.ack), 32'd0);
    check_eq("rst_commit", 32'(commit_dval), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_count", 32'(dut.u_fifo.count), 32'd0);

    // Back-to-back issue, pcs 0..3
    for (int k = 0; k < 4; k++) begin s_pc[k] = k; s_wid[k] = k; end
    alu_bus.ack = 1'b1;
    start_stream(4);
    check_eq("b2b_c0_inst_ack", 32'(inst_bus.ack), 32'd1);
    check_eq("b2b_c0_alu_rdy", 32'(alu_bus.rdy), 32'd0);
    tick(1'b0);
    check_eq("b2b_c1_alu_rdy", 32'(alu_bus.rdy), 32'd0);
    for (int c = 2; c <= 5; c++) begin
      tick(1'b0);
      check_eq("b2b_alu_rdy", 32'(alu_bus.rdy), 32'd1);
      check_eq("b2b_opcode", 32'(alu_bus.opcode), 32'(5 + c - 2));
      check_eq("b2b_src_sel", 32'(alu_bus.src_sel), 32'(c - 2));
      check_eq("b2b_pc", 32'(alu_bus.pc), 32'(c - 2));
      check_eq("b2b_warpid", 32'(alu_bus.warpid), 32'(c - 2));
      check_eq("b2b_bofs", 32'(alu_bus.bofs), 32'(tag_bofs(c - 1)));
      check_eq("b2b_aofs", 32'(alu_bus.aofs), 32'(tag_aofs(c - 1)));
    end
    tick(1'b0);
    check_eq("b2b_c6_alu_rdy", 32'(alu_bus.rdy), 32'd0);
    check_eq("b2b_c6_count", 32'(dut.u_fifo.count), 32'd4);

    // Commit ordering: warps 3,1,2
    do_reset();
    s_pc[0] = 0; s_wid[0] = 3;
    s_pc[1] = 1; s_wid[1] = 1;
    s_pc[2] = 2; s_wid[2] = 2;
    alu_bus.ack = 1'b1;
    start_stream(3);
    for (int c = 0; c < 5; c++) tick(1'b0);
    for (int c = 5; c <= 9; c++) begin
      check_eq("ord_commit_dval", 32'(commit_dval), (c >= 6 && c <= 8) ? 32'd1 : 32'd0);
      if (c == 6) check_eq("ord_wid0", 32'(commit_wid), 32'd3);
      if (c == 7) check_eq("ord_wid1", 32'(commit_wid), 32'd1);
      if (c == 8) check_eq("ord_wid2", 32'(commit_wid), 32'd2);
      tick(c <= 7);
    end
    check_eq("ord_count", 32'(dut.u_fifo.count), 32'd0);

    // Full queue: ops 1..6 plus a 7th waiting upstream
    do_reset();
    for (int k = 0; k < 7; k++) begin s_pc[k] = k % 4; s_wid[k] = (k + 1) % 4; end
    alu_bus.ack = 1'b1;
    start_stream(7);
    for (int c = 0; c < 6; c++) tick(1'b0);
    check_eq("full_alu_rdy", 32'(alu_bus.rdy), 32'd0);
    check_eq("full_inst_ack", 32'(inst_bus.ack), 32'd0);
    check_eq("full_count", 32'(dut.u_fifo.count), 32'd4);
    check_eq("full_i_op5", 32'(alu_bus.bofs), 32'(tag_bofs(5)));
    check_eq("full_d_valid", 32'(dut.r_d_valid), 32'd1);
    check_eq("full_d_op6", 32'(dut.r_d_bofs), 32'(tag_bofs(6)));
    tick(1'b1);
    check_eq("full_rel_alu_rdy", 32'(alu_bus.rdy), 32'd1);
    check_eq("full_rel_op5", 32'(alu_bus.bofs), 32'(tag_bofs(5)));
    check_eq("full_rel_commit", 32'(commit_dval), 32'd1);
    check_eq("full_rel_wid", 32'(commit_wid), 32'd1);
    check_eq("full_rel_inst_ack", 32'(inst_bus.ack), 32'd1);
    tick(1'b0);
    check_eq("full_c8_alu_rdy", 32'(alu_bus.rdy), 32'd0);
    check_eq("full_c8_commit", 32'(commit_dval), 32'd0);
    check_eq("full_c8_op6", 32'(alu_bus.bofs), 32'(tag_bofs(6)));

    // 20 ops with done every cycle from cycle 5: pointers wrap repeatedly
    do_reset();
    for (int k = 0; k < 20; k++) begin s_pc[k] = k % 4; s_wid[k] = k % 4; end
    alu_bus.ack = 1'b1;
    start_stream(20);
    for (int c = 0; c < 5; c++) tick(1'b0);
    for (int c = 5; c <= 22; c++) begin
      if (c >= 6) begin
        check_eq("wrap_count", 32'(dut.u_fifo.count), 32'd3);
        check_eq("wrap_commit", 32'(commit_dval), 32'd1);
        check_eq("wrap_wid", 32'(commit_wid), 32'((c - 6) % 4));
      end
      tick(c <= 21);
    end
    check_eq("wrap_end_commit", 32'(commit_dval), 32'd0);

    // Out-of-range pc decodes to NOP and still commits
    do_reset();
    s_pc[0] = N_INST; s_wid[0] = 2;
    alu_bus.ack = 1'b1;
    start_stream(1);
    tick(1'b0);
    tick(1'b0);
    check_eq("oor_alu_rdy", 32'(alu_bus.rdy), 32'd1);
    check_eq("oor_opcode", 32'(alu_bus.opcode), 32'd0);
    check_eq("oor_pc", 32'(alu_bus.pc), 32'(N_INST));
    tick(1'b0);
    tick(1'b1);
    check_eq("oor_commit", 32'(commit_dval), 32'd1);
    check_eq("oor_wid", 32'(commit_wid), 32'd2);
    check_eq("oor_err", 32'(err), 32'd0);

    // Done with an empty queue
    tick(1'b1);
    check_eq("unf_commit", 32'(commit_dval), 32'd0);
    check_eq("unf_err", 32'(err), 32'd1);
    check_eq("unf_count", 32'(dut.u_fifo.count), 32'd0);

    // Reset with two ops pending
    s_pc[0] = 2; s_wid[0] = 1;
    s_pc[1] = 3; s_wid[1] = 3;
    start_stream(2);
    for (int c = 0; c < 4; c++) tick(1'b0);
    check_eq("mid_count", 32'(dut.u_fifo.count), 32'd2);
    check_eq("mid_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    check_eq("mid_rst_alu_rdy", 32'(alu_bus.rdy), 32'd0);
    check_eq("mid_rst_commit", 32'(commit_dval), 32'd0);
    check_eq("mid_rst_err", 32'(err), 32'd0);
    check_eq("mid_rst_count", 32'(dut.u_fifo.count), 32'd0);
    check_eq("mid_rst_opcode", 32'(alu_bus.opcode), 32'd0);

    // Clean issue after reset
    s_pc[0] = 3; s_wid[0] = 3;
    start_stream(1);
    tick(1'b0);
    tick(1'b0);
    check_eq("post_alu_rdy", 32'(alu_bus.rdy), 32'd1);
    check_eq("post_opcode", 32'(alu_bus.opcode), 32'd8);
    check_eq("post_warpid", 32'(alu_bus.warpid), 32'd3);
    tick(1'b0);
    tick(1'b1);
    check_eq("post_commit", 32'(commit_dval), 32'd1);
    check_eq("post_wid", 32'(commit_wid), 32'd3);
    check_eq("post_err", 32'(err), 32'd0);

    // Done in the same cycle as a push into an empty queue
    s_pc[0] = 1; s_wid[0] = 2;
    start_stream(1);
    tick(1'b0);
    tick(1'b0);
    check_eq("same_alu_rdy", 32'(alu_bus.rdy), 32'd1);
    tick(1'b1);
    check_eq("same_commit", 32'(commit_dval), 32'd0);
    check_eq("same_err", 32'(err), 32'd1);
    check_eq("same_count", 32'(dut.u_fifo.count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
